// File: rtl/commit_pkg.sv
// Shared definitions for the commit unit.
// Holds the lane count, the no-writeback type code, index widths and the FSM state type.
// Also holds a helper that counts the set bits in a lane mask.
package commit_pkg;

  localparam int unsigned NUM_LANES = 3;
  localparam int unsigned PHYS_W    = 5;
  localparam int unsigned ARCH_W    = 3;
  localparam int unsigned RCNT_W    = 4;
  localparam int unsigned LCNT_W    = 2;
  localparam logic [1:0]  TYPE_NOREG = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } commit_state_e;

  // Returns the number of set bits in a lane mask.
  function automatic logic [LCNT_W-1:0] lane_count(input logic [NUM_LANES-1:0] mask);
    lane_count = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      lane_count = lane_count + LCNT_W'(mask[i]);
    end
  endfunction

endpackage

// File: rtl/commit_arch_rat.sv
// Committed architectural register alias table.
// Holds ARCH_REGS x PHYS_W entries and resets to the identity map.
// Ports: clk, rst (sync, active high); wr_en/wr_rw/wr_pw are per-lane write ports;
//        map is the full table.
// When several lanes write one entry in the same cycle, the highest lane wins.
module commit_arch_rat
  import commit_pkg::*;
#(
  parameter int unsigned ARCH_REGS = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_LANES-1:0]                 wr_en,
  input  logic [NUM_LANES-1:0][ARCH_W-1:0]     wr_rw,
  input  logic [NUM_LANES-1:0][PHYS_W-1:0]     wr_pw,
  output logic [ARCH_REGS-1:0][PHYS_W-1:0]     map
);

  // Lanes are scanned oldest first, so the last matching assignment is the youngest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(ARCH_REGS); r++) begin
        map[r] <= PHYS_W'(r);
      end
    end else begin
      for (int r = 0; r < int'(ARCH_REGS); r++) begin
        for (int l = 0; l < int'(NUM_LANES); l++) begin
          if (wr_en[l] && (wr_rw[l] == ARCH_W'(r))) begin
            map[r] <= wr_pw[l];
          end
        end
      end
    end
  end

endmodule

// File: rtl/commit_unit.sv
// Retirement stage.
// Commits up to three in-order ROB head lanes, updates the committed RAT and
// releases old physical registers. On an exception it runs the sequence
// FLUSH (1 cycle) -> RECOVER (RECOVER_CYCLES cycles) -> IDLE.
// Ports: clk, rst (sync, active high); *_ret carry ROB head lane info (lane 0 oldest);
//        free_valid/free_Pw carry released registers; arch_map is the committed map;
//        flush, freeze_front and recover_valid carry recovery control.
// Optional macro COMMIT_PERF_CNT_EN adds the commit_cnt/flush_cnt performance counters.
module commit_unit
  import commit_pkg::*;
#(
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned ARCH_REGS      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_LANES-1:0]                 ready_ret,
  input  logic [NUM_LANES-1:0]                 excep_ret,
  input  logic [NUM_LANES-1:0][1:0]            Type_ret,
  input  logic [NUM_LANES-1:0][PHYS_W-1:0]     Pw_ret,
  input  logic [NUM_LANES-1:0][PHYS_W-1:0]     Pw_old_ret,
  input  logic [NUM_LANES-1:0][ARCH_W-1:0]     Rw_ret,
  output logic [NUM_LANES-1:0]                 free_valid,
  output logic [NUM_LANES-1:0][PHYS_W-1:0]     free_Pw,
  output logic [ARCH_REGS-1:0][PHYS_W-1:0]     arch_map,
  output logic                                 flush,
  output logic                                 freeze_front,
  output logic                                 recover_valid
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [31:0]                          commit_cnt,
  output logic [31:0]                          flush_cnt
`endif
);

  commit_state_e           state_q, state_d;
  logic [RCNT_W-1:0]       rcnt_q, rcnt_d;
  logic [NUM_LANES-1:0]    commit;
  logic [NUM_LANES-1:0]    wr_en;
  logic                    exc_detect;
  logic                    prefix_ok;

  // Lane commit and exception detection: a lane commits only if every older lane commits.
  always_comb begin
    commit     = '0;
    wr_en      = '0;
    exc_detect = 1'b0;
    prefix_ok  = (state_q == ST_IDLE);
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (prefix_ok && ready_ret[i] && excep_ret[i]) begin
        exc_detect = 1'b1;
      end
      prefix_ok = prefix_ok && ready_ret[i] && !excep_ret[i];
      commit[i] = prefix_ok;
      wr_en[i]  = prefix_ok && (Type_ret[i] != TYPE_NOREG);
    end
  end

  // Next-state logic for the recovery FSM; the down-counter covers the RECOVER length.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_detect) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d = ST_RECOVER;
        rcnt_d  = RCNT_W'(RECOVER_CYCLES - 1);
      end
      ST_RECOVER: begin
        if (rcnt_q == '0) state_d = ST_IDLE;
        else              rcnt_d  = rcnt_q - RCNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; control outputs track the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rcnt_q        <= '0;
      flush         <= 1'b0;
      freeze_front  <= 1'b0;
      recover_valid <= 1'b0;
      free_valid    <= '0;
      free_Pw       <= '0;
    end else begin
      state_q       <= state_d;
      rcnt_q        <= rcnt_d;
      flush         <= (state_d == ST_FLUSH);
      freeze_front  <= (state_d != ST_IDLE);
      recover_valid <= (state_d == ST_RECOVER);
      free_valid    <= wr_en;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        free_Pw[i] <= wr_en[i] ? Pw_old_ret[i] : '0;
      end
    end
  end

  commit_arch_rat #(
    .ARCH_REGS (ARCH_REGS)
  ) u_rat (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .wr_rw (Rw_ret),
    .wr_pw (Pw_ret),
    .map   (arch_map)
  );

`ifdef COMMIT_PERF_CNT_EN
  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      commit_cnt <= commit_cnt + 32'(lane_count(commit));
      if (exc_detect) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: table vectors, directed recovery/reset
// sequences, and randomized traffic against an in-order retirement model.
module tb_commit_unit;
  import commit_pkg::*;

  localparam int unsigned RCY = 2;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]      ready_ret, excep_ret;
  logic [2:0][1:0] Type_ret;
  logic [2:0][4:0] Pw_ret, Pw_old_ret;
  logic [2:0][2:0] Rw_ret;
  logic [2:0]      free_valid;
  logic [2:0][4:0] free_Pw;
  logic [7:0][4:0] arch_map;
  logic            flush, freeze_front, recover_valid;
`ifdef COMMIT_PERF_CNT_EN
  logic [31:0]     commit_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  commit_unit #(
    .RECOVER_CYCLES (RCY),
    .ARCH_REGS      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ready_ret     (ready_ret),
    .excep_ret     (excep_ret),
    .Type_ret      (Type_ret),
    .Pw_ret        (Pw_ret),
    .Pw_old_ret    (Pw_old_ret),
    .Rw_ret        (Rw_ret),
    .free_valid    (free_valid),
    .free_Pw       (free_Pw),
    .arch_map      (arch_map),
    .flush         (flush),
    .freeze_front  (freeze_front),
    .recover_valid (recover_valid)
`ifdef COMMIT_PERF_CNT_EN
    ,
    .commit_cnt    (commit_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  // ---------------- reference model ----------------
  logic [7:0][4:0] em;      // committed map
  logic [2:0]      efv;     // expected free_valid
  logic [2:0][4:0] efpw;    // expected free_Pw
  int              busy;    // cycles of flush+recover still ahead

  task automatic model_edge();
    bit stop;
    efv  = '0;
    efpw = '0;
    if (rst) begin
      for (int r = 0; r < 8; r++) em[r] = 5'(r);
      busy = 0;
    end else if (busy > 0) begin
      busy--;
    end else begin
      stop = 0;
      for (int i = 0; i < 3; i++) begin
        if (!stop) begin
          if (!ready_ret[i]) stop = 1;
          else if (excep_ret[i]) begin
            busy = 1 + int'(RCY);
            stop = 1;
          end else if (Type_ret[i] != 2'b11) begin
            em[Rw_ret[i]] = Pw_ret[i];
            efv[i]  = 1'b1;
            efpw[i] = Pw_old_ret[i];
          end
        end
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_fv"}, 64'(free_valid), 64'(efv));
    for (int i = 0; i < 3; i++)
      if (efv[i]) chk({tag, "_fpw"}, 64'(free_Pw[i]), 64'(efpw[i]));
    chk({tag, "_map"}, 64'(arch_map), 64'(em));
    chk({tag, "_flush"}, 64'(flush), 64'(busy == 1 + int'(RCY)));
    chk({tag, "_freeze"}, 64'(freeze_front), 64'(busy > 0));
    chk({tag, "_recv"}, 64'(recover_valid), 64'(busy > 0 && busy <= int'(RCY)));
  endtask

  function automatic logic [2:0][4:0] p5(input int a0, input int a1, input int a2);
    p5[0] = 5'(a0); p5[1] = 5'(a1); p5[2] = 5'(a2);
  endfunction
  function automatic logic [2:0][2:0] p3(input int a0, input int a1, input int a2);
    p3[0] = 3'(a0); p3[1] = 3'(a1); p3[2] = 3'(a2);
  endfunction
  function automatic logic [2:0][1:0] p2(input int a0, input int a1, input int a2);
    p2[0] = 2'(a0); p2[1] = 2'(a1); p2[2] = 2'(a2);
  endfunction

  task automatic drive(input logic [2:0] rdy, input logic [2:0] exc, input logic [2:0][1:0] typ,
                       input logic [2:0][2:0] rw, input logic [2:0][4:0] pw, input logic [2:0][4:0] pwo);
    ready_ret = rdy; excep_ret = exc; Type_ret = typ;
    Rw_ret = rw; Pw_ret = pw; Pw_old_ret = pwo;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]      rdy, exc;
    logic [2:0][1:0] typ;
    logic [2:0][2:0] rw;
    logic [2:0][4:0] pw, pwo;
    logic [2:0]      fv;
    logic [2:0][4:0] fpw;
    logic            fl;
    logic [7:0][4:0] map;
  } vec_t;

  vec_t            tbl[9];
  logic [7:0][4:0] ident;

  initial begin
    for (int r = 0; r < 8; r++) ident[r] = 5'(r);

    // {ready, excep, type, Rw, Pw, Pw_old} -> {free_valid, free_Pw, flush, arch_map}
    tbl[0] = '{3'b111, 3'b000, p2(0,0,0), p3(1,2,3), p5(8,9,10),   p5(1,2,3),  3'b111, p5(1,2,3),  1'b0, ident};
    tbl[0].map[1] = 5'd8; tbl[0].map[2] = 5'd9; tbl[0].map[3] = 5'd10;
    tbl[1] = '{3'b011, 3'b000, p2(3,0,0), p3(4,6,0), p5(12,13,0),  p5(4,6,0),  3'b010, p5(0,6,0),  1'b0, ident};
    tbl[1].map[6] = 5'd13;
    tbl[2] = '{3'b111, 3'b000, p2(0,1,2), p3(5,5,5), p5(20,21,22), p5(5,17,18), 3'b111, p5(5,17,18), 1'b0, ident};
    tbl[2].map[5] = 5'd22;
    tbl[3] = '{3'b111, 3'b001, p2(0,0,0), p3(1,2,3), p5(8,9,10),   p5(1,2,3),  3'b000, p5(0,0,0),  1'b1, ident};
    tbl[4] = '{3'b110, 3'b010, p2(0,0,0), p3(1,2,3), p5(8,9,10),   p5(1,2,3),  3'b000, p5(0,0,0),  1'b0, ident};
    tbl[5] = '{3'b001, 3'b010, p2(0,0,0), p3(7,2,3), p5(30,9,10),  p5(7,2,3),  3'b001, p5(7,0,0),  1'b0, ident};
    tbl[5].map[7] = 5'd30;
    tbl[6] = '{3'b101, 3'b000, p2(0,0,0), p3(1,2,3), p5(8,9,10),   p5(1,2,3),  3'b001, p5(1,0,0),  1'b0, ident};
    tbl[6].map[1] = 5'd8;
    tbl[7] = '{3'b111, 3'b100, p2(0,0,0), p3(1,2,3), p5(8,9,10),   p5(1,2,3),  3'b011, p5(1,2,0),  1'b1, ident};
    tbl[7].map[1] = 5'd8; tbl[7].map[2] = 5'd9;
    tbl[8] = '{3'b111, 3'b010, p2(3,0,0), p3(1,2,3), p5(8,9,10),   p5(1,2,3),  3'b000, p5(0,0,0),  1'b1, ident};

    rst = 1'b0;
    drive('0, '0, '0, '0, '0, '0);
    em = ident; efv = '0; efpw = '0; busy = 0;

    // Reset state
    do_reset();
    chk("rst_fv", 64'(free_valid), 64'(0));
    chk("rst_fpw", 64'(free_Pw), 64'(0));
    chk("rst_map", 64'(arch_map), 64'(ident));
    chk("rst_ctl", 64'({flush, freeze_front, recover_valid}), 64'(0));

    // Table vectors, each from a fresh reset
    for (int v = 0; v < 9; v++) begin
      do_reset();
      drive(tbl[v].rdy, tbl[v].exc, tbl[v].typ, tbl[v].rw, tbl[v].pw, tbl[v].pwo);
      cycle();
      chk($sformatf("vec%0d_fv", v), 64'(free_valid), 64'(tbl[v].fv));
      for (int i = 0; i < 3; i++)
        if (tbl[v].fv[i]) chk($sformatf("vec%0d_fpw%0d", v, i), 64'(free_Pw[i]), 64'(tbl[v].fpw[i]));
      chk($sformatf("vec%0d_flush", v), 64'(flush), 64'(tbl[v].fl));
      chk($sformatf("vec%0d_map", v), 64'(arch_map), 64'(tbl[v].map));
    end

    // Lane 1 exception: flush 1 cycle, recover RCY cycles, inputs ignored meanwhile
    do_reset();
    drive(3'b011, 3'b010, p2(0,0,0), p3(2,4,0), p5(15,16,0), p5(2,4,0));
    cycle();
    chk("exc_fv", 64'(free_valid), 64'(3'b001));
    chk("exc_fpw0", 64'(free_Pw[0]), 64'(2));
    chk("exc_ctl0", 64'({flush, freeze_front, recover_valid}), 64'(3'b110));
    drive(3'b111, 3'b000, p2(0,0,0), p3(3,4,6), p5(25,26,27), p5(3,4,6));
    cycle();
    chk("exc_ctl1", 64'({flush, freeze_front, recover_valid}), 64'(3'b011));
    chk("exc_fv1", 64'(free_valid), 64'(0));
    cycle();
    chk("exc_ctl2", 64'({flush, freeze_front, recover_valid}), 64'(3'b011));
    chk("exc_hold", 64'(arch_map[3:2]), 64'({5'd3, 5'd15}));
    cycle();
    chk("exc_ctl3", 64'({flush, freeze_front, recover_valid}), 64'(3'b000));
    chk("exc_fv3", 64'(free_valid), 64'(0));
    cycle();
    chk("exc_resume_fv", 64'(free_valid), 64'(3'b111));
    chk("exc_resume_map", 64'(arch_map[3]), 64'(25));

    // Reset during RECOVER aborts recovery
    do_reset();
    drive(3'b001, 3'b001, p2(0,0,0), p3(0,0,0), p5(0,0,0), p5(0,0,0));
    cycle();
    drive('0, '0, '0, '0, '0, '0);
    cycle();
    chk("abort_pre", 64'(recover_valid), 64'(1));
    do_reset();
    chk("abort_ctl", 64'({flush, freeze_front, recover_valid}), 64'(0));
    chk("abort_fv", 64'({free_valid, free_Pw}), 64'(0));
    chk("abort_map", 64'(arch_map), 64'(ident));
    cycle();
    chk("abort_noflush", 64'({flush, freeze_front}), 64'(0));

`ifdef COMMIT_PERF_CNT_EN
    // 3 + 2 commits then one lane-0 exception
    do_reset();
    drive(3'b111, 3'b000, p2(0,0,0), p3(1,2,3), p5(8,9,10), p5(1,2,3));
    cycle();
    drive(3'b011, 3'b000, p2(0,0,0), p3(4,5,0), p5(11,12,0), p5(4,5,0));
    cycle();
    drive(3'b001, 3'b001, p2(0,0,0), p3(0,0,0), p5(0,0,0), p5(0,0,0));
    cycle();
    drive('0, '0, '0, '0, '0, '0);
    cycle();
    chk("perf_commit", 64'(commit_cnt), 64'(5));
    chk("perf_flush", 64'(flush_cnt), 64'(1));
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        ready_ret[i]  = ($urandom_range(0, 3) != 0);
        excep_ret[i]  = ($urandom_range(0, 9) == 0);
        Type_ret[i]   = 2'($urandom);
        Rw_ret[i]     = 3'($urandom);
        Pw_ret[i]     = 5'($urandom);
        Pw_old_ret[i] = 5'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      chk_model("rnd");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
